alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-issue pipeline stage directly upstream of the combinational ALU.
- Accepts decoded instructions (op, register operands, immediate, destination) over a valid/ready handshake.
- Selects and bypasses operands and encodes the ALU controls (add_sub, LogicFn, FnClass) into registered outputs that drive the ALU.
- Two-entry buffering (output register plus skid register) allows full throughput under backpressure; an EX->EX bypass feeds the ALU result back into dependent instructions.

Parameters:
- XLEN, 32, datapath width of x, y, operands and ex_result.
- IMM_W, 16, immediate field width; LUI places it in y[IMM_W-1:0] (the ALU shifts it up).
- RIDX_W, 5, register index width; index 0 is hard-zero and never bypassed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; registered, equals ~skid_valid.
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 LUI; 8-15 illegal.
- in_use_imm  in  1  y operand comes from immediate instead of rs2.
- in_imm  in  IMM_W  immediate field.
- in_rs1_idx, in_rs2_idx  in  RIDX_W each  source register indices.
- in_rs1_val, in_rs2_val  in  XLEN each  register file read data.
- in_rd  in  RIDX_W  destination index.
- in_trap  in  1  instruction traps on signed overflow.
- flush  in  1  squash all held instructions.
- out_valid  out  1  x/y/controls valid to ALU.
- out_ready  in  1  downstream accepts this cycle.
- x, y  out  XLEN each  ALU operands.
- add_sub  out  1  1 = subtract; y is passed uninverted (the ALU inverts it).
- LogicFn  out  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- FnClass  out  2  00 LUI, 01 set-less, 10 arithmetic, 11 logic.
- out_rd  out  RIDX_W  destination of the held instruction.
- illegal_op  out  1  held instruction carries an illegal op.
- ex_result  in  XLEN  ALU_result of the held instruction (combinational return).
- ex_overflow  in  1  ALU Overflow of the held instruction.
- ovf_trap  out  1  overflow trap pulse (feature-dependent).

Behaviour:
- Reset: out_valid=0, in_ready=1, skid empty, x=y=0, add_sub=0, LogicFn=00, FnClass=00, out_rd=0, illegal_op=0, ovf_trap=0.
- Latency: an instruction accepted at edge N appears on the outputs after edge N when the output register is free. Throughput is one instruction per cycle while out_ready=1.
- Accept: in_valid & in_ready at a rising edge.
- Output register load:
  - Loads when it is empty or its instruction departs (out_valid & out_ready).
  - Source is the skid entry if valid, else the incoming instruction.
- Skid register: captures the incoming instruction when accepted while the output register holds and does not depart. in_ready deasserts the next cycle.
- Decode:
  - ADD/SUB: FnClass 10, add_sub 0/1.
  - AND/OR/XOR/NOR: FnClass 11, LogicFn 00/01/10/11, add_sub 0.
  - SLT: FnClass 01, add_sub 1.
  - LUI: FnClass 00, x=0, y = zero-extended in_imm.
  - Illegal ops: FnClass 10, add_sub 0, x=y=0, illegal_op=1. They are passed through and never trap.
- Immediate:
  - Sign-extended for ADD/SUB/SLT.
  - Zero-extended for the logic ops.
- Bypass:
  - Applied at output-register load time for each non-immediate source.
  - If the departing held instruction has out_valid=1, out_rd!=0, out_rd==src_idx and illegal_op=0, the source uses ex_result.
  - A skid entry is bypassed at load time in the same way; operand values are not re-captured while waiting.
  - Older results are the register file's responsibility (write-through).
- Flush:
  - Synchronous; clears out_valid and the skid entry; in_ready=1 the next cycle.
  - Overrides a simultaneous accept: the accepted instruction is dropped.
- Stall: while out_valid & ~out_ready, x/y/controls/out_rd stay stable.
- Simultaneous depart and accept with an empty skid: the output register reloads directly and the skid stays empty.
- Reset mid-operation: all held instructions are discarded.

Optional Feature:
- Macro: ALU_ISSUE_OVF_TRAP_EN.
- Defined:
  - On departure of an ADD/SUB with in_trap set and ex_overflow=1, ovf_trap pulses high for one cycle after that edge.
  - The skid entry (the younger instruction) is squashed on the same edge, and in_ready is forced 0 for that cycle.
- Undefined: ovf_trap is tied 0; ex_overflow and in_trap are ignored.

Test Plan:
- Reset, then ADD rs1=5, rs2=3 with out_ready=1 -> next cycle out_valid=1, x=5, y=3, FnClass=10, add_sub=0.
- SLT with use_imm, imm=16'hFFFF -> y=32'hFFFFFFFF, FnClass=01, add_sub=1. ORI with imm=16'hFFFF -> y=32'h0000FFFF, LogicFn=01.
- ADD r3 followed back-to-back by SUB r4=r3-r1, with ex_result=32'h10 -> SUB has x=32'h10, not in_rs1_val. A dependent instruction on r0 is not bypassed.
- out_ready=0 for 3 cycles while 2 instructions are sent -> second goes to skid, in_ready=0, outputs stable. Release -> both emerge in order, no loss or duplication.
- flush asserted with output and skid full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted.
- ALU_ISSUE_OVF_TRAP_EN defined: ADD with in_trap=1 and ex_overflow=1 at departure -> ovf_trap=1 for one cycle and skid entry squashed. Same case with the macro undefined -> ovf_trap stays 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: selects/bypasses operands and encodes ALU controls into registered ALU inputs.
// Latency: an instruction accepted at edge N drives x/y/controls after edge N when the output register is free.
// Backpressure: output + skid register pair; in_ready (registered) drops only while the skid entry is occupied.
// Optional: define ALU_ISSUE_OVF_TRAP_EN to enable the signed-overflow trap pulse on ovf_trap.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 16,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [RIDX_W-1:0] in_rs1_idx,
    input  logic [RIDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_trap,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   x,
    output logic [XLEN-1:0]   y,
    output logic              add_sub,
    output logic [1:0]        LogicFn,
    output logic [1:0]        FnClass,
    output logic [RIDX_W-1:0] out_rd,
    output logic              illegal_op,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ex_overflow,
    output logic              ovf_trap
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_LUI = 4'd7;

    // output register
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   x_q, x_d, y_q, y_d;
    logic              add_sub_q, add_sub_d;
    logic [1:0]        logic_fn_q, logic_fn_d, fn_class_q, fn_class_d;
    logic [RIDX_W-1:0] out_rd_q, out_rd_d;
    logic              illegal_q, illegal_d;
    logic              out_trap_q, out_trap_d;   // held op is ADD/SUB with in_trap set
    logic              ovf_trap_q, ovf_trap_d;

    // skid register keeps the raw instruction; decode and bypass happen when it moves up
    logic              skid_valid_q, skid_valid_d;
    logic [3:0]        skid_op_q, skid_op_d;
    logic              skid_use_imm_q, skid_use_imm_d;
    logic [IMM_W-1:0]  skid_imm_q, skid_imm_d;
    logic [RIDX_W-1:0] skid_rs1_idx_q, skid_rs1_idx_d, skid_rs2_idx_q, skid_rs2_idx_d;
    logic [XLEN-1:0]   skid_rs1_val_q, skid_rs1_val_d, skid_rs2_val_q, skid_rs2_val_d;
    logic [RIDX_W-1:0] skid_rd_q, skid_rd_d;
    logic              skid_trap_q, skid_trap_d;

    logic depart, accept, load_en, byp_en, trap_fire;
    logic [3:0]        src_op;
    logic              src_use_imm, src_trap;
    logic [IMM_W-1:0]  src_imm;
    logic [RIDX_W-1:0] src_rs1_idx, src_rs2_idx, src_rd;
    logic [XLEN-1:0]   src_a, src_b, imm_ext;
    logic [XLEN-1:0]   dec_x, dec_y;
    logic              dec_add_sub, dec_illegal, dec_trap;
    logic [1:0]        dec_logic_fn, dec_fn_class;

`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign trap_fire = depart & out_trap_q & ex_overflow;
    assign in_ready  = ~skid_valid_q & ~ovf_trap_q;
`else
    logic unused_trap;
    assign unused_trap = ^{ex_overflow, out_trap_q};
    assign trap_fire   = 1'b0;
    assign in_ready    = ~skid_valid_q;
`endif

    assign depart  = out_valid_q & out_ready;
    assign accept  = in_valid & in_ready;
    assign load_en = ~out_valid_q | depart;
    // only the departing instruction forwards; r0 and illegal ops never forward
    assign byp_en  = depart & (out_rd_q != '0) & ~illegal_q;

    // pick the instruction that would enter the output register and apply the EX->EX bypass
    always_comb begin
        src_op      = skid_valid_q ? skid_op_q      : in_op;
        src_use_imm = skid_valid_q ? skid_use_imm_q : in_use_imm;
        src_imm     = skid_valid_q ? skid_imm_q     : in_imm;
        src_rs1_idx = skid_valid_q ? skid_rs1_idx_q : in_rs1_idx;
        src_rs2_idx = skid_valid_q ? skid_rs2_idx_q : in_rs2_idx;
        src_rd      = skid_valid_q ? skid_rd_q      : in_rd;
        src_trap    = skid_valid_q ? skid_trap_q    : in_trap;
        src_a       = skid_valid_q ? skid_rs1_val_q : in_rs1_val;
        src_b       = skid_valid_q ? skid_rs2_val_q : in_rs2_val;
        if (byp_en && (out_rd_q == src_rs1_idx)) src_a = ex_result;
        if (byp_en && (out_rd_q == src_rs2_idx)) src_b = ex_result;
    end

    // decode op into ALU controls and operand routing
    always_comb begin
        if (src_op == OP_ADD || src_op == OP_SUB || src_op == OP_SLT)
            imm_ext = {{(XLEN-IMM_W){src_imm[IMM_W-1]}}, src_imm};
        else
            imm_ext = {{(XLEN-IMM_W){1'b0}}, src_imm};
        dec_x        = src_a;
        dec_y        = src_use_imm ? imm_ext : src_b;
        dec_add_sub  = 1'b0;
        dec_logic_fn = 2'b00;
        dec_fn_class = 2'b10;
        dec_illegal  = 1'b0;
        case (src_op)
            OP_ADD: dec_add_sub = 1'b0;
            OP_SUB: dec_add_sub = 1'b1;
            OP_AND: begin dec_fn_class = 2'b11; dec_logic_fn = 2'b00; end
            OP_OR:  begin dec_fn_class = 2'b11; dec_logic_fn = 2'b01; end
            OP_XOR: begin dec_fn_class = 2'b11; dec_logic_fn = 2'b10; end
            OP_NOR: begin dec_fn_class = 2'b11; dec_logic_fn = 2'b11; end
            OP_SLT: begin dec_fn_class = 2'b01; dec_add_sub = 1'b1; end
            OP_LUI: begin
                dec_fn_class = 2'b00;
                dec_x        = '0;
                dec_y        = {{(XLEN-IMM_W){1'b0}}, src_imm};
            end
            default: begin
                dec_illegal = 1'b1;
                dec_x       = '0;
                dec_y       = '0;
            end
        endcase
        dec_trap = src_trap & ((src_op == OP_ADD) | (src_op == OP_SUB));
    end

    // next state of output and skid registers: load, skid capture, trap squash, flush
    always_comb begin
        out_valid_d    = out_valid_q;
        x_d            = x_q;
        y_d            = y_q;
        add_sub_d      = add_sub_q;
        logic_fn_d     = logic_fn_q;
        fn_class_d     = fn_class_q;
        out_rd_d       = out_rd_q;
        illegal_d      = illegal_q;
        out_trap_d     = out_trap_q;
        skid_valid_d   = skid_valid_q;
        skid_op_d      = skid_op_q;
        skid_use_imm_d = skid_use_imm_q;
        skid_imm_d     = skid_imm_q;
        skid_rs1_idx_d = skid_rs1_idx_q;
        skid_rs2_idx_d = skid_rs2_idx_q;
        skid_rs1_val_d = skid_rs1_val_q;
        skid_rs2_val_d = skid_rs2_val_q;
        skid_rd_d      = skid_rd_q;
        skid_trap_d    = skid_trap_q;

        if (load_en) begin
            out_valid_d = skid_valid_q | accept;
            if (skid_valid_q || accept) begin
                x_d        = dec_x;
                y_d        = dec_y;
                add_sub_d  = dec_add_sub;
                logic_fn_d = dec_logic_fn;
                fn_class_d = dec_fn_class;
                out_rd_d   = src_rd;
                illegal_d  = dec_illegal;
                out_trap_d = dec_trap;
            end
        end

        if (skid_valid_q) begin
            skid_valid_d = ~load_en;
        end else if (accept && !load_en) begin
            skid_valid_d   = 1'b1;
            skid_op_d      = in_op;
            skid_use_imm_d = in_use_imm;
            skid_imm_d     = in_imm;
            skid_rs1_idx_d = in_rs1_idx;
            skid_rs2_idx_d = in_rs2_idx;
            skid_rs1_val_d = in_rs1_val;
            skid_rs2_val_d = in_rs2_val;
            skid_rd_d      = in_rd;
            skid_trap_d    = in_trap;
        end

        // overflow trap kills the younger skid entry instead of promoting it
        if (trap_fire && skid_valid_q) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end

        ovf_trap_d = trap_fire & ~flush;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            add_sub_q      <= 1'b0;
            logic_fn_q     <= 2'b00;
            fn_class_q     <= 2'b00;
            out_rd_q       <= '0;
            illegal_q      <= 1'b0;
            out_trap_q     <= 1'b0;
            ovf_trap_q     <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_op_q      <= '0;
            skid_use_imm_q <= 1'b0;
            skid_imm_q     <= '0;
            skid_rs1_idx_q <= '0;
            skid_rs2_idx_q <= '0;
            skid_rs1_val_q <= '0;
            skid_rs2_val_q <= '0;
            skid_rd_q      <= '0;
            skid_trap_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            x_q            <= x_d;
            y_q            <= y_d;
            add_sub_q      <= add_sub_d;
            logic_fn_q     <= logic_fn_d;
            fn_class_q     <= fn_class_d;
            out_rd_q       <= out_rd_d;
            illegal_q      <= illegal_d;
            out_trap_q     <= out_trap_d;
            ovf_trap_q     <= ovf_trap_d;
            skid_valid_q   <= skid_valid_d;
            skid_op_q      <= skid_op_d;
            skid_use_imm_q <= skid_use_imm_d;
            skid_imm_q     <= skid_imm_d;
            skid_rs1_idx_q <= skid_rs1_idx_d;
            skid_rs2_idx_q <= skid_rs2_idx_d;
            skid_rs1_val_q <= skid_rs1_val_d;
            skid_rs2_val_q <= skid_rs2_val_d;
            skid_rd_q      <= skid_rd_d;
            skid_trap_q    <= skid_trap_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign add_sub    = add_sub_q;
    assign LogicFn    = logic_fn_q;
    assign FnClass    = fn_class_q;
    assign out_rd     = out_rd_q;
    assign illegal_op = illegal_q;
    assign ovf_trap   = ovf_trap_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table, directed multi-cycle sequences and random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven from stimulus; the model tracks a two-deep in-order queue.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic        in_trap, flush;
    logic        out_valid, out_ready;
    logic [31:0] x, y;
    logic        add_sub;
    logic [1:0]  LogicFn, FnClass;
    logic [4:0]  out_rd;
    logic        illegal_op;
    logic [31:0] ex_result;
    logic        ex_overflow, ovf_trap;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rd(in_rd), .in_trap(in_trap), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .add_sub(add_sub), .LogicFn(LogicFn), .FnClass(FnClass),
        .out_rd(out_rd), .illegal_op(illegal_op),
        .ex_result(ex_result), .ex_overflow(ex_overflow), .ovf_trap(ovf_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        use_imm;
        logic [15:0] imm;
        logic [4:0]  rs1_idx, rs2_idx;
        logic [31:0] rs1_val, rs2_val;
        logic [4:0]  rd;
        logic        trap;
    } instr_t;

    typedef struct {
        logic [31:0] x, y;
        logic        as;
        logic [1:0]  lf, fc;
        logic [4:0]  rd;
        logic        ill;
    } dec_t;

    typedef struct {
        instr_t i;
        dec_t   e;
    } vec_t;

    typedef struct {
        instr_t r;
        dec_t   d;
        bit     res;
    } entry_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input instr_t i);
        in_valid   = 1'b1;
        in_op      = i.op;
        in_use_imm = i.use_imm;
        in_imm     = i.imm;
        in_rs1_idx = i.rs1_idx;
        in_rs2_idx = i.rs2_idx;
        in_rs1_val = i.rs1_val;
        in_rs2_val = i.rs2_val;
        in_rd      = i.rd;
        in_trap    = i.trap;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_op = '0; in_use_imm = 1'b0; in_imm = '0;
        in_rs1_idx = '0; in_rs2_idx = '0; in_rs1_val = '0; in_rs2_val = '0;
        in_rd = '0; in_trap = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ex_result = '0; ex_overflow = 1'b0;
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic ui, input logic [15:0] imm,
                                  input logic [4:0] r1i, input logic [31:0] r1v,
                                  input logic [4:0] r2i, input logic [31:0] r2v,
                                  input logic [4:0] rd, input logic trap);
        instr_t i;
        i.op = op; i.use_imm = ui; i.imm = imm;
        i.rs1_idx = r1i; i.rs1_val = r1v; i.rs2_idx = r2i; i.rs2_val = r2v;
        i.rd = rd; i.trap = trap;
        return i;
    endfunction

    function automatic dec_t ex(input logic [31:0] ex_x, input logic [31:0] ex_y, input logic as,
                                input logic [1:0] lf, input logic [1:0] fc, input logic [4:0] rd,
                                input logic ill);
        dec_t d;
        d.x = ex_x; d.y = ex_y; d.as = as; d.lf = lf; d.fc = fc; d.rd = rd; d.ill = ill;
        return d;
    endfunction

    // ---------------- reference model ----------------
    entry_t mq[$];
    bit     m_trap;

    function automatic dec_t model_decode(input instr_t r, input logic [31:0] a, input logic [31:0] b);
        dec_t d;
        logic [31:0] zimm, simm;
        zimm = 32'(r.imm);
        simm = (r.imm >= 16'h8000) ? zimm + 32'hFFFF_0000 : zimm;
        d.rd = r.rd; d.ill = 1'b0; d.as = 1'b0; d.lf = 2'b00; d.fc = 2'b10; d.x = a;
        if (r.op <= 4'd1 || r.op == 4'd6) d.y = r.use_imm ? simm : b;
        else                              d.y = r.use_imm ? zimm : b;
        if (r.op == 4'd1) d.as = 1'b1;
        else if (r.op >= 4'd2 && r.op <= 4'd5) begin d.fc = 2'b11; d.lf = 2'(r.op - 4'd2); end
        else if (r.op == 4'd6) begin d.fc = 2'b01; d.as = 1'b1; end
        else if (r.op == 4'd7) begin d.fc = 2'b00; d.x = 0; d.y = zimm; end
        else if (r.op >= 4'd8) begin d.ill = 1'b1; d.x = 0; d.y = 0; end
        return d;
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit depart, accept, byp, new_trap;
        logic [4:0] brd;
        entry_t h, n;
        logic [31:0] a, b;
        depart = (mq.size() > 0) && out_ready;
        accept = in_valid && (mq.size() < 2) && !m_trap;
        byp = 0; brd = 0; new_trap = 0;
        if (rst) begin
            mq.delete();
            m_trap = 0;
            return;
        end
        if (depart) begin
            h = mq.pop_front();
            byp = (h.d.rd != 0) && !h.d.ill;
            brd = h.d.rd;
`ifdef ALU_ISSUE_OVF_TRAP_EN
            if (h.r.trap && h.r.op <= 4'd1 && ex_overflow && !flush) begin
                new_trap = 1;
                mq.delete();
            end
`endif
        end
        if (flush) mq.delete();
        else if (accept) begin
            n.r.op = in_op; n.r.use_imm = in_use_imm; n.r.imm = in_imm;
            n.r.rs1_idx = in_rs1_idx; n.r.rs2_idx = in_rs2_idx;
            n.r.rs1_val = in_rs1_val; n.r.rs2_val = in_rs2_val;
            n.r.rd = in_rd; n.r.trap = in_trap; n.res = 0;
            mq.push_back(n);
        end
        if (mq.size() > 0 && !mq[0].res) begin
            a = (byp && brd == mq[0].r.rs1_idx) ? ex_result : mq[0].r.rs1_val;
            b = (byp && brd == mq[0].r.rs2_idx) ? ex_result : mq[0].r.rs2_val;
            mq[0].d = model_decode(mq[0].r, a, b);
            mq[0].res = 1;
        end
        m_trap = new_trap;
    endtask

    function automatic instr_t rnd_instr();
        instr_t i;
        i.op      = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
        i.use_imm = 1'($urandom_range(0, 1));
        i.imm     = 16'($urandom);
        i.rs1_idx = 5'($urandom_range(0, 7));
        i.rs2_idx = 5'($urandom_range(0, 7));
        i.rs1_val = $urandom;
        i.rs2_val = $urandom;
        i.rd      = 5'($urandom_range(0, 7));
        i.trap    = 1'($urandom_range(0, 1));
        return i;
    endfunction

    vec_t tbl[13];

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        // reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_x", x, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_add_sub", 32'(add_sub), 32'd0);
        check("rst_LogicFn", 32'(LogicFn), 32'd0);
        check("rst_FnClass", 32'(FnClass), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_ovf_trap", 32'(ovf_trap), 32'd0);
        rst = 1'b0;

        // decode vectors; r0 sources so no forwarding is involved
        tbl[0]  = '{mk(4'd0, 0, 16'h0000, 0, 32'd5, 0, 32'd3, 1, 0),       ex(32'd5, 32'd3, 0, 0, 2'b10, 1, 0)};
        tbl[1]  = '{mk(4'd1, 0, 16'h0000, 0, 32'd10, 0, 32'd4, 2, 0),      ex(32'd10, 32'd4, 1, 0, 2'b10, 2, 0)};
        tbl[2]  = '{mk(4'd2, 0, 16'h0000, 0, 32'hF0F0, 0, 32'h0FF0, 3, 0), ex(32'hF0F0, 32'h0FF0, 0, 2'b00, 2'b11, 3, 0)};
        tbl[3]  = '{mk(4'd3, 1, 16'hFFFF, 0, 32'd1, 0, 32'hDEAD, 4, 0),    ex(32'd1, 32'h0000FFFF, 0, 2'b01, 2'b11, 4, 0)};
        tbl[4]  = '{mk(4'd4, 0, 16'h0000, 0, 32'hA, 0, 32'hC, 5, 0),       ex(32'hA, 32'hC, 0, 2'b10, 2'b11, 5, 0)};
        tbl[5]  = '{mk(4'd5, 1, 16'h8001, 0, 32'h3, 0, 32'h9, 6, 0),       ex(32'h3, 32'h00008001, 0, 2'b11, 2'b11, 6, 0)};
        tbl[6]  = '{mk(4'd6, 1, 16'hFFFF, 0, 32'd7, 0, 32'd0, 7, 0),       ex(32'd7, 32'hFFFFFFFF, 1, 0, 2'b01, 7, 0)};
        tbl[7]  = '{mk(4'd7, 0, 16'h1234, 0, 32'd99, 0, 32'd55, 8, 0),     ex(32'd0, 32'h00001234, 0, 0, 2'b00, 8, 0)};
        tbl[8]  = '{mk(4'd0, 1, 16'h8000, 0, 32'd2, 0, 32'd9, 9, 0),       ex(32'd2, 32'hFFFF8000, 0, 0, 2'b10, 9, 0)};
        tbl[9]  = '{mk(4'd1, 1, 16'h7FFF, 0, 32'd2, 0, 32'd9, 10, 0),      ex(32'd2, 32'h00007FFF, 1, 0, 2'b10, 10, 0)};
        tbl[10] = '{mk(4'd8, 0, 16'h0000, 0, 32'd5, 0, 32'd6, 11, 0),      ex(32'd0, 32'd0, 0, 0, 2'b10, 11, 1)};
        tbl[11] = '{mk(4'd15, 1, 16'h1111, 0, 32'd5, 0, 32'd6, 12, 0),     ex(32'd0, 32'd0, 0, 0, 2'b10, 12, 1)};
        tbl[12] = '{mk(4'd6, 0, 16'h0000, 0, 32'd3, 0, 32'd9, 13, 0),      ex(32'd3, 32'd9, 1, 0, 2'b01, 13, 0)};

        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            apply(tbl[k].i);
            tick();
            check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_x", k), x, tbl[k].e.x);
            check($sformatf("vec%0d_y", k), y, tbl[k].e.y);
            check($sformatf("vec%0d_FnClass", k), 32'(FnClass), 32'(tbl[k].e.fc));
            check($sformatf("vec%0d_illegal", k), 32'(illegal_op), 32'(tbl[k].e.ill));
            check($sformatf("vec%0d_out_rd", k), 32'(out_rd), 32'(tbl[k].e.rd));
            if (tbl[k].e.fc != 2'b00)
                check($sformatf("vec%0d_add_sub", k), 32'(add_sub), 32'(tbl[k].e.as));
            if (tbl[k].e.fc == 2'b11)
                check($sformatf("vec%0d_LogicFn", k), 32'(LogicFn), 32'(tbl[k].e.lf));
        end
        idle();
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // back-to-back dependency: SUB r4 = r3 - r1 right after ADD r3
        apply(mk(4'd0, 0, 0, 1, 32'd1, 2, 32'd2, 3, 0));
        tick();
        apply(mk(4'd1, 0, 0, 3, 32'h99, 1, 32'd7, 4, 0));
        ex_result = 32'h10;
        tick();
        check("byp_sub_x", x, 32'h10);
        check("byp_sub_y", y, 32'd7);
        check("byp_sub_add_sub", 32'(add_sub), 32'd1);
        // instruction writing r0, then a reader of r0: never forwarded
        apply(mk(4'd0, 0, 0, 5, 32'd1, 6, 32'd2, 0, 0));
        ex_result = 32'h20;
        tick();
        check("byp_nomatch_x", x, 32'd1);
        apply(mk(4'd0, 0, 0, 0, 32'd7, 0, 32'd8, 6, 0));
        ex_result = 32'h55;
        tick();
        check("byp_r0_x", x, 32'd7);
        check("byp_r0_y", y, 32'd8);
        idle();
        tick();

        // backpressure: second instruction to skid, third refused, release drains in order
        out_ready = 1'b0;
        apply(mk(4'd0, 0, 0, 1, 32'h11, 2, 32'h22, 6, 0));
        tick();
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_in_ready", 32'(in_ready), 32'd1);
        apply(mk(4'd1, 0, 0, 6, 32'h33, 2, 32'h44, 7, 0));
        tick();
        check("bp_skid_in_ready", 32'(in_ready), 32'd0);
        check("bp_skid_x_stable", x, 32'h11);
        apply(mk(4'd2, 0, 0, 1, 32'h77, 2, 32'h77, 8, 0));
        tick();
        check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_x", x, 32'h11);
        check("bp_hold_y", y, 32'h22);
        check("bp_hold_out_rd", 32'(out_rd), 32'd6);
        check("bp_hold_FnClass", 32'(FnClass), 32'b10);
        idle();
        ex_result = 32'hABC;
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_x_byp", x, 32'hABC);
        check("bp_second_y", y, 32'h44);
        check("bp_second_out_rd", 32'(out_rd), 32'd7);
        check("bp_second_add_sub", 32'(add_sub), 32'd1);
        check("bp_second_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // flush with output and skid full plus a new instruction offered
        out_ready = 1'b0;
        apply(mk(4'd0, 0, 0, 1, 32'd1, 2, 32'd2, 1, 0));
        tick();
        apply(mk(4'd0, 0, 0, 1, 32'd3, 2, 32'd4, 2, 0));
        tick();
        check("fl_full_in_ready", 32'(in_ready), 32'd0);
        apply(mk(4'd0, 0, 0, 1, 32'd5, 2, 32'd6, 3, 0));
        flush = 1'b1;
        tick();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        idle();
        tick();
        check("fl_nothing_emitted", 32'(out_valid), 32'd0);

        // reset in the middle of held work
        out_ready = 1'b0;
        apply(mk(4'd0, 0, 0, 1, 32'd1, 2, 32'd2, 1, 0));
        tick();
        apply(mk(4'd0, 0, 0, 1, 32'd3, 2, 32'd4, 2, 0));
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);

        // overflow on departure of a trapping ADD with a younger op in skid
        out_ready = 1'b0;
        apply(mk(4'd0, 0, 0, 1, 32'h7FFFFFFF, 2, 32'd1, 2, 1));
        tick();
        apply(mk(4'd1, 0, 0, 1, 32'd9, 5, 32'd1, 3, 0));
        tick();
        idle();
        ex_overflow = 1'b1;
        tick();
        ex_overflow = 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        check("ovf_pulse", 32'(ovf_trap), 32'd1);
        check("ovf_skid_squashed", 32'(out_valid), 32'd0);
        check("ovf_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("ovf_pulse_end", 32'(ovf_trap), 32'd0);
        check("ovf_in_ready_back", 32'(in_ready), 32'd1);
        check("ovf_nothing_emitted", 32'(out_valid), 32'd0);
`else
        check("ovf_off_no_pulse", 32'(ovf_trap), 32'd0);
        check("ovf_off_skid_kept", 32'(out_valid), 32'd1);
        check("ovf_off_skid_rd", 32'(out_rd), 32'd3);
        tick();
        check("ovf_off_still_no_pulse", 32'(ovf_trap), 32'd0);
        check("ovf_off_drained", 32'(out_valid), 32'd0);
`endif

        // random traffic against the queue model
        idle();
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            apply(rnd_instr());
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 39) == 0);
            ex_result   = $urandom;
            ex_overflow = ($urandom_range(0, 3) == 0);
            model_step();
            tick();
            check("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("rnd_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !m_trap));
            check("rnd_ovf_trap", 32'(ovf_trap), 32'(m_trap));
            if (mq.size() > 0) begin
                check("rnd_x", x, mq[0].d.x);
                check("rnd_y", y, mq[0].d.y);
                check("rnd_FnClass", 32'(FnClass), 32'(mq[0].d.fc));
                check("rnd_out_rd", 32'(out_rd), 32'(mq[0].d.rd));
                check("rnd_illegal", 32'(illegal_op), 32'(mq[0].d.ill));
                if (mq[0].d.fc != 2'b00)
                    check("rnd_add_sub", 32'(add_sub), 32'(mq[0].d.as));
                if (mq[0].d.fc == 2'b11)
                    check("rnd_LogicFn", 32'(LogicFn), 32'(mq[0].d.lf));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
